// File: rtl/pixel_writeback_unit_pkg.sv
// Shared types and constants for the pixel write-back unit.
// Holds the write-FSM state encoding, pixel/lane geometry, clamp limits
// and a helper that builds the byte-enable mask for a partial word.
package pixel_writeback_unit_pkg;

  typedef enum logic [0:0] {
    WB_IDLE = 1'b0,
    WB_REQ  = 1'b1
  } wb_state_e;

  localparam int PIX_W   = 8;
  localparam int LANES   = 4;
  localparam int LANE_W  = $clog2(LANES);
  localparam int WORD_W  = PIX_W * LANES;
  localparam int PIX_MIN = 0;
  localparam int PIX_MAX = 255;

  // Lanes 0..k-1 valid: (1 << k) - 1
  function automatic logic [LANES-1:0] lane_mask(input logic [LANE_W-1:0] k);
    logic [LANES-1:0] m;
    m = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(k)) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/pixel_writeback_unit_if.sv
// Result-bus and memory-write bundle for the pixel write-back unit.
// master = the write-back unit, slave = ALU result source plus data memory.
interface pixel_writeback_unit_if #(
  parameter int ADDR_W = 16
) ();
  logic [31:0]       c_bus;
  logic              result_valid;
  logic              result_ready;
  logic              mem_wr_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_byte_en;
  logic              mem_wr_ack;

  modport master (
    input  c_bus, result_valid, mem_wr_ack,
    output result_ready, mem_wr_req, mem_addr, mem_wdata, mem_byte_en
  );

  modport slave (
    output c_bus, result_valid, mem_wr_ack,
    input  result_ready, mem_wr_req, mem_addr, mem_wdata, mem_byte_en
  );
endinterface

// File: rtl/pixel_writeback_unit_wb_fifo.sv
// wb_fifo: synchronous show-ahead FIFO holding packed words plus byte enables.
// DEPTH must be a power of two so the pointers wrap naturally.
// A push while full is accepted only when a pop happens in the same cycle.
module wb_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == CNT_ZERO);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= CNT_ZERO;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/pixel_writeback_unit.sv
// pixel_writeback_unit: converts 32-bit ALU results to 8-bit pixels, packs four
// per word, queues words in wb_fifo and writes them to memory over req/ack.
// Build option: define PIXEL_CLAMP_EN for saturating conversion and a clip
// counter; otherwise pixels are truncated and o_clip_count reads zero.
module pixel_writeback_unit
  import pixel_writeback_unit_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [ADDR_W-1:0]      i_base_addr,
  input  logic                   i_flush,
  output logic                   o_busy,
  output logic                   o_flush_done,
  output logic [15:0]            o_clip_count,
  pixel_writeback_unit_if.master bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int FIFO_W = WORD_W + LANES;
  localparam logic [LANE_W-1:0] LANE_ZERO = {LANE_W{1'b0}};
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

  logic [PIX_W-1:0]  w_pix;
  logic              w_xfer;
  logic              w_start_ok;
  logic [LANE_W-1:0] r_lane;
  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] w_packed;
  logic              w_fill_last;
  logic              w_flush_part;
  logic              w_flush_fin;
  logic              r_flush_pending;
  logic              r_flush_done;
  logic              w_push;
  logic [FIFO_W-1:0] w_push_data;
  logic [FIFO_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  wb_state_e         r_state;
  wb_state_e         w_state_nxt;
  logic              w_load;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_mem_wr_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata;
  logic [LANES-1:0]  r_mem_byte_en;

  // ---------------- pixel conversion ----------------
`ifdef PIXEL_CLAMP_EN
  logic signed [31:0] w_c_s;
  logic               w_below;
  logic               w_above;
  logic               w_clip;
  logic [15:0]        r_clip_count;

  assign w_c_s = $signed(bus.c_bus);

  // Saturate to the pixel range and flag clamped results.
  always_comb begin
    w_below = (w_c_s < PIX_MIN);
    w_above = (w_c_s > PIX_MAX);
    w_clip  = w_below || w_above;
    if (w_below) begin
      w_pix = PIX_W'(PIX_MIN);
    end else if (w_above) begin
      w_pix = PIX_W'(PIX_MAX);
    end else begin
      w_pix = bus.c_bus[PIX_W-1:0];
    end
  end

  // Count clamped pixels since start, holding at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_clip_count <= 16'h0000;
    end else if (w_start_ok) begin
      r_clip_count <= 16'h0000;
    end else if (w_xfer && w_clip && (r_clip_count != 16'hFFFF)) begin
      r_clip_count <= r_clip_count + 16'h0001;
    end
  end

  assign o_clip_count = r_clip_count;
`else
  logic [31-PIX_W:0] w_unused_c_hi;

  assign w_pix         = bus.c_bus[PIX_W-1:0];
  assign w_unused_c_hi = bus.c_bus[31:PIX_W];
  assign o_clip_count  = 16'h0000;
`endif

  // ---------------- handshake and packer ----------------
  assign o_busy            = (r_lane != LANE_ZERO) || (w_count != CNT_ZERO) || (r_state == WB_REQ);
  assign bus.result_ready  = !w_full && !r_flush_pending && !i_reset;
  assign w_xfer            = bus.result_valid && bus.result_ready;
  assign w_start_ok        = i_start && !o_busy;
  assign w_fill_last       = w_xfer && (r_lane == LANE_LAST);
  // Partial word leaves the cycle after flush, so a coinciding pixel is packed first.
  assign w_flush_part      = r_flush_pending && (r_lane != LANE_ZERO) && !w_full;
  assign w_flush_fin       = r_flush_pending && w_empty && (r_state == WB_IDLE) && (r_lane == LANE_ZERO);

  // Current word with the incoming pixel dropped into its lane.
  always_comb begin
    w_packed = r_word;
    w_packed[int'(r_lane)*PIX_W +: PIX_W] = w_pix;
  end

  // Select what enters the FIFO: a full word or a flushed partial word.
  always_comb begin
    w_push      = w_fill_last || w_flush_part;
    if (w_fill_last) begin
      w_push_data = {{LANES{1'b1}}, w_packed};
    end else begin
      w_push_data = {lane_mask(r_lane), r_word};
    end
  end

  // Lane counter and word accumulator; cleared whenever a word leaves.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lane <= LANE_ZERO;
      r_word <= {WORD_W{1'b0}};
    end else if (w_fill_last || w_flush_part) begin
      r_lane <= LANE_ZERO;
      r_word <= {WORD_W{1'b0}};
    end else if (w_xfer) begin
      r_lane <= r_lane + LANE_W'(1);
      r_word <= w_packed;
    end else if (w_start_ok) begin
      r_lane <= LANE_ZERO;
      r_word <= {WORD_W{1'b0}};
    end
  end

  // Flush bookkeeping: pending until queue drains, then a one-cycle done pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_flush_pending <= 1'b0;
      r_flush_done    <= 1'b0;
    end else begin
      r_flush_done <= w_flush_fin;
      if (i_flush) begin
        r_flush_pending <= 1'b1;
      end else if (w_flush_fin) begin
        r_flush_pending <= 1'b0;
      end
    end
  end

  assign o_flush_done = r_flush_done;

  wb_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_wdata (w_push_data),
    .i_pop   (w_load),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // ---------------- write FSM ----------------
  // Write FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= WB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; w_load moves the FIFO head into the request registers.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      WB_IDLE: begin
        if (!w_empty) begin
          w_load      = 1'b1;
          w_state_nxt = WB_REQ;
        end else begin
          w_state_nxt = WB_IDLE;
        end
      end
      WB_REQ: begin
        if (bus.mem_wr_ack && !w_empty) begin
          w_load      = 1'b1;
          w_state_nxt = WB_REQ;
        end else if (bus.mem_wr_ack) begin
          w_state_nxt = WB_IDLE;
        end else begin
          w_state_nxt = WB_REQ;
        end
      end
      default: begin
        w_state_nxt = WB_IDLE;
      end
    endcase
  end

  // Write address: loaded on start, advanced as each word is handed to memory.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_addr <= {ADDR_W{1'b0}};
    end else if (w_load) begin
      r_wr_addr <= r_wr_addr + ADDR_W'(1);
    end else if (w_start_ok) begin
      r_wr_addr <= i_base_addr;
    end
  end

  // Request registers, held stable until the head is replaced.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem_wr_req  <= 1'b0;
      r_mem_addr    <= {ADDR_W{1'b0}};
      r_mem_wdata   <= {WORD_W{1'b0}};
      r_mem_byte_en <= {LANES{1'b0}};
    end else begin
      r_mem_wr_req <= (w_state_nxt == WB_REQ);
      if (w_load) begin
        r_mem_addr    <= r_wr_addr;
        r_mem_wdata   <= w_head[WORD_W-1:0];
        r_mem_byte_en <= w_head[FIFO_W-1:WORD_W];
      end
    end
  end

  assign bus.mem_wr_req  = r_mem_wr_req;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.mem_byte_en = r_mem_byte_en;
endmodule

// File: tb/tb_pixel_writeback_unit.sv
// Directed bench for pixel_writeback_unit: packing, clamp/truncate, flush,
// backpressure, reset during a request, and address wrap on a 4-bit instance.
module tb_pixel_writeback_unit;
  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic        flush;
  logic        busy;
  logic        flush_done;
  logic [15:0] clip_count;

  logic        start4;
  logic [3:0]  base4;
  logic        flush4;
  logic        busy4;
  logic        flush_done4;
  logic [15:0] clip4;

  int n_cmp;
  int n_err;

  logic [15:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [3:0]  wq_be[$];
  logic [3:0]  wq4_addr[$];

  pixel_writeback_unit_if #(.ADDR_W(16)) bus ();
  pixel_writeback_unit_if #(.ADDR_W(4))  bus4 ();

  pixel_writeback_unit #(.ADDR_W(16), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_base_addr(base_addr),
    .i_flush(flush), .o_busy(busy), .o_flush_done(flush_done),
    .o_clip_count(clip_count), .bus(bus)
  );

  pixel_writeback_unit #(.ADDR_W(4), .FIFO_DEPTH(4)) dut4 (
    .i_clk(clk), .i_reset(reset), .i_start(start4), .i_base_addr(base4),
    .i_flush(flush4), .o_busy(busy4), .o_flush_done(flush_done4),
    .o_clip_count(clip4), .bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted memory write.
  always @(posedge clk) begin
    if (bus.mem_wr_req && bus.mem_wr_ack) begin
      wq_addr.push_back(bus.mem_addr);
      wq_data.push_back(bus.mem_wdata);
      wq_be.push_back(bus.mem_byte_en);
    end
    if (bus4.mem_wr_req && bus4.mem_wr_ack) begin
      wq4_addr.push_back(bus4.mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] v);
    bit got;
    got = 1'b0;
    @(negedge clk);
    bus.c_bus = v;
    bus.result_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk);
      if (bus.result_ready) got = 1'b1;
    end
    chk("send_accept", 64'(got), 64'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.result_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n, input string tag);
    for (int i = 0; i < 200 && wq_addr.size() < n; i++) @(negedge clk);
    chk(tag, 64'(wq_addr.size()), 64'(n));
  endtask

  task automatic do_start(input logic [15:0] a);
    @(negedge clk);
    start = 1'b1;
    base_addr = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int acc;
    bit seen;
    logic [31:0] exp_w;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0;
    base_addr = 16'h0000;
    flush = 1'b0;
    start4 = 1'b0;
    base4 = 4'h0;
    flush4 = 1'b0;
    bus.c_bus = 32'h0;
    bus.result_valid = 1'b0;
    bus.mem_wr_ack = 1'b1;
    bus4.c_bus = 32'h0;
    bus4.result_valid = 1'b0;
    bus4.mem_wr_ack = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.result_ready), 64'd0);
    chk("rst_req", 64'(bus.mem_wr_req), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_be", 64'(bus.mem_byte_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(flush_done), 64'd0);
    chk("rst_clip", 64'(clip_count), 64'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 64'(bus.result_ready), 64'd1);

    // Full word, zero-wait ack
    do_start(16'h0100);
    send(32'd1); send(32'd2); send(32'd3); send(32'd4);
    idle();
    wait_writes(1, "w1_count");
    chk("w1_addr", 64'(wq_addr[0]), 64'h0100);
    chk("w1_data", 64'(wq_data[0]), 64'h04030201);
    chk("w1_be", 64'(wq_be[0]), 64'hF);
    @(negedge clk);
    chk("w1_busy_low", 64'(busy), 64'd0);

    // Clamp / truncate
    do_start(16'h0200);
    send(32'hFFFF_FFFB); send(32'd300); send(32'd255); send(32'd0);
    idle();
    wait_writes(2, "w2_count");
    chk("w2_addr", 64'(wq_addr[1]), 64'h0200);
`ifdef PIXEL_CLAMP_EN
    chk("w2_data", 64'(wq_data[1]), 64'h00FFFF00);
    chk("w2_clip", 64'(clip_count), 64'd2);
`else
    chk("w2_data", 64'(wq_data[1]), 64'h00FF2CFB);
    chk("w2_clip", 64'(clip_count), 64'd0);
`endif

    // Partial flush
    do_start(16'h0300);
    send(32'd7); send(32'd9);
    idle();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready_low", 64'(bus.result_ready), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (flush_done) seen = 1'b1;
    end
    chk("flush_done_seen", 64'(seen), 64'd1);
    chk("flush_write_before_done", 64'(wq_addr.size()), 64'd3);
    chk("w3_addr", 64'(wq_addr[2]), 64'h0300);
    chk("w3_data", 64'(wq_data[2]), 64'h00000907);
    chk("w3_be", 64'(wq_be[2]), 64'h3);
    chk("flush_busy_low", 64'(busy), 64'd0);
    @(negedge clk);
    chk("flush_done_pulse", 64'(flush_done), 64'd0);

    // Backpressure: ack held low, stream up to 24 pixels
    do_start(16'h0400);
    bus.mem_wr_ack = 1'b0;
    acc = 0;
    for (int i = 0; i < 60 && acc < 24; i++) begin
      @(negedge clk);
      bus.c_bus = 32'(acc + 1);
      bus.result_valid = 1'b1;
      @(posedge clk);
      if (bus.result_ready) acc++;
    end
    @(negedge clk);
    bus.result_valid = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd20);
    chk("bp_ready_low", 64'(bus.result_ready), 64'd0);
    chk("bp_req_held", 64'(bus.mem_wr_req), 64'd1);
    chk("bp_addr_held", 64'(bus.mem_addr), 64'h0400);
    bus.mem_wr_ack = 1'b1;
    wait_writes(8, "bp_count");
    for (int j = 0; j < 5; j++) begin
      exp_w = {8'(4*j+4), 8'(4*j+3), 8'(4*j+2), 8'(4*j+1)};
      chk("bp_addr", 64'(wq_addr[3+j]), 64'(16'h0400 + 16'(j)));
      chk("bp_data", 64'(wq_data[3+j]), 64'(exp_w));
    end
    @(negedge clk);
    chk("bp_busy_low", 64'(busy), 64'd0);

    // Reset while a request is outstanding with another word queued
    do_start(16'h0500);
    bus.mem_wr_ack = 1'b0;
    for (int i = 0; i < 8; i++) send(32'(8'h20 + i));
    idle();
    repeat (3) @(negedge clk);
    chk("rr_req_before", 64'(bus.mem_wr_req), 64'd1);
    reset = 1'b1;
    #1;
    chk("rr_ready_in_reset", 64'(bus.result_ready), 64'd0);
    @(negedge clk);
    bus.mem_wr_ack = 1'b1;
    chk("rr_req_cleared", 64'(bus.mem_wr_req), 64'd0);
    chk("rr_busy_cleared", 64'(busy), 64'd0);
    reset = 1'b0;
    #1;
    chk("rr_ready_after", 64'(bus.result_ready), 64'd1);
    repeat (10) @(negedge clk);
    chk("rr_no_writes", 64'(wq_addr.size()), 64'd8);
    chk("rr_req_idle", 64'(bus.mem_wr_req), 64'd0);

    // Flush with nothing buffered: done one cycle later
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("ef_done_early", 64'(flush_done), 64'd0);
    @(negedge clk);
    chk("ef_done", 64'(flush_done), 64'd1);
    @(negedge clk);
    chk("ef_done_end", 64'(flush_done), 64'd0);

    // Address wrap on the 4-bit instance
    @(negedge clk);
    start4 = 1'b1;
    base4 = 4'hF;
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen = 1'b0;
      @(negedge clk);
      bus4.c_bus = 32'(i + 1);
      bus4.result_valid = 1'b1;
      for (int k = 0; k < 50 && !seen; k++) begin
        @(posedge clk);
        if (bus4.result_ready) seen = 1'b1;
      end
      chk("wrap_accept", 64'(seen), 64'd1);
    end
    @(negedge clk);
    bus4.result_valid = 1'b0;
    for (int i = 0; i < 100 && wq4_addr.size() < 2; i++) @(negedge clk);
    chk("wrap_count", 64'(wq4_addr.size()), 64'd2);
    chk("wrap_addr0", 64'(wq4_addr[0]), 64'hF);
    chk("wrap_addr1", 64'(wq4_addr[1]), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
